pcg_noise_bank: RTL and testbench

- Parametrised multi-channel PCG-style pseudo-random noise generator for the VGA/audio demoscene path.
- N_CH independent LCG streams share one control FSM, one sample-and-hold counter and one seed handshake.
- Each channel produces an OUT_W-bit permuted sample plus a density-thresholded mask bit. Pixel/audio glitch logic combines these with PMOD signals downstream.

---
 rtl/pcg_noise_pkg.sv | 48 ++++
 rtl/pcg_noise_bank_if.sv | 41 ++++
 rtl/pcg_lane.sv | 66 ++++++
 rtl/pcg_noise_bank.sv | 115 +++++++++++
 tb/tb_pcg_noise_bank.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcg_noise_pkg.sv
// rtl/pcg_noise_pkg.sv - shared types, default constants and PCG arithmetic helpers
//
// Contents:
//   fsm_state_e    control FSM states (RUN, WARM0, WARM1)
//   DEF_*          default generator constants
//   lcg_step()     one LCG advance, wrapped to w bits
//   lcg_perm()     output permutation of a w-bit state down to out_w bits
package pcg_noise_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WARM0 = 2'd1,
    WARM1 = 2'd2
  } fsm_state_e;

  localparam int DEF_MULT         = 12829;
  localparam int DEF_BASE_INC     = 47989;
  localparam int DEF_OUT_MULT     = 62169;
  localparam int DEF_DEFAULT_SEED = 4356;

  // Helpers work on a 64-bit carrier so one function serves any width up
  // to 32 bits; callers size-cast the result back to their own width.
  function automatic logic [63:0] width_mask(input int unsigned w);
    return (w >= 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] lcg_step(input logic [63:0] s,
                                           input logic [63:0] mult,
                                           input logic [63:0] inc,
                                           input int unsigned w);
    return (s * mult + inc) & width_mask(w);
  endfunction

  function automatic logic [63:0] lcg_perm(input logic [63:0] s,
                                           input logic [63:0] out_mult,
                                           input int unsigned w,
                                           input int unsigned out_w);
    int unsigned sh;
    logic [63:0] x;
    logic [63:0] y;
    // Shift amount comes from the top three state bits, so it ranges 3..10.
    sh = 32'((s >> (w - 32'd3)) & 64'd7) + 32'd3;
    x  = (s >> sh) ^ s;
    y  = (x * out_mult) & width_mask(w);
    return (y >> (w - out_w)) & width_mask(out_w);
  endfunction

endpackage

// File: rtl/pcg_noise_bank_if.sv
// rtl/pcg_noise_bank_if.sv - control, seed handshake and sample output bundle
//
// Signals:
//   en          global advance enable
//   hold_len    extra cycles each sample is held
//   density     mask threshold
//   seed_valid  seed offer
//   seed        seed value (channel c gets seed + c)
//   seed_ready  generator can accept a seed (RUN only)
//   out_data    packed samples, channel c at [c*OUT_W +: OUT_W]
//   out_mask    per-channel sample < density
//   out_valid   one-cycle pulse on each sample update
// Modports: master drives control/seed, slave is the generator.
interface pcg_noise_bank_if #(
  parameter int STATE_W = 16,
  parameter int OUT_W   = 8,
  parameter int N_CH    = 4,
  parameter int HOLD_W  = 8
) ();

  logic                    en;
  logic [HOLD_W-1:0]       hold_len;
  logic [OUT_W-1:0]        density;
  logic                    seed_valid;
  logic [STATE_W-1:0]      seed;
  logic                    seed_ready;
  logic [N_CH*OUT_W-1:0]   out_data;
  logic [N_CH-1:0]         out_mask;
  logic                    out_valid;

  modport master (
    output en, hold_len, density, seed_valid, seed,
    input  seed_ready, out_data, out_mask, out_valid
  );

  modport slave (
    input  en, hold_len, density, seed_valid, seed,
    output seed_ready, out_data, out_mask, out_valid
  );

endinterface

// File: rtl/pcg_lane.sv
// rtl/pcg_lane.sv - one PCG noise channel: LCG state, permuted sample and mask
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   tick         advance state and register a new sample/mask
//   load_zero    clear state (seed accepted)
//   add_seed     state <= step(0) + seed + CH
//   warm_step    advance state without touching outputs
//   seed         latched seed value
//   density      mask threshold
//   out_data     registered sample of the pre-step state
//   out_mask     registered (sample < density)
module pcg_lane import pcg_noise_pkg::*; #(
  parameter int STATE_W      = 16,
  parameter int OUT_W        = 8,
  parameter int CH           = 0,
  parameter int MULT         = DEF_MULT,
  parameter int BASE_INC     = DEF_BASE_INC,
  parameter int OUT_MULT     = DEF_OUT_MULT,
  parameter int DEFAULT_SEED = DEF_DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               load_zero,
  input  logic               add_seed,
  input  logic               warm_step,
  input  logic [STATE_W-1:0] seed,
  input  logic [OUT_W-1:0]   density,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_mask
);

  // Per-channel odd increment keeps every lane on a full-period sequence.
  localparam logic [63:0] INC64 = 64'((BASE_INC + 2 * CH) | 1);
  localparam logic [63:0] RST64 = 64'(DEFAULT_SEED) + 64'(CH);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] step_next;
  logic [STATE_W-1:0] warm_next;
  logic [OUT_W-1:0]   sample;

  assign step_next = STATE_W'(lcg_step(64'(state_q), 64'(MULT), INC64, STATE_W));
  // step(0) collapses to the increment, so warm-up adds seed + CH to it.
  assign warm_next = STATE_W'(INC64 + 64'(seed) + 64'(CH));
  assign sample    = OUT_W'(lcg_perm(64'(state_q), 64'(OUT_MULT), STATE_W, OUT_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STATE_W'(RST64);
      out_data <= '0;
      out_mask <= 1'b0;
    end else if (load_zero) begin
      state_q <= '0;
    end else if (add_seed) begin
      state_q <= warm_next;
    end else if (warm_step) begin
      state_q <= step_next;
    end else if (tick) begin
      state_q  <= step_next;
      out_data <= sample;
      out_mask <= (sample < density);
    end
  end

endmodule

// File: rtl/pcg_noise_bank.sv
// rtl/pcg_noise_bank.sv - multi-channel PCG noise generator with hold and seeding
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          pcg_noise_bank_if slave: en/hold_len/density control,
//                seed_valid/seed/seed_ready handshake,
//                out_data/out_mask/out_valid sample stream
module pcg_noise_bank import pcg_noise_pkg::*; #(
  parameter int STATE_W      = 16,
  parameter int OUT_W        = 8,
  parameter int N_CH         = 4,
  parameter int MULT         = DEF_MULT,
  parameter int BASE_INC     = DEF_BASE_INC,
  parameter int OUT_MULT     = DEF_OUT_MULT,
  parameter int DEFAULT_SEED = DEF_DEFAULT_SEED,
  parameter int HOLD_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pcg_noise_bank_if.slave  bus
);

  fsm_state_e            fsm_q, fsm_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [STATE_W-1:0]    seed_q;
  logic                  out_valid_q;
  logic                  seed_ready;
  logic                  seed_acc;
  logic                  tick;
  logic                  add_seed;
  logic                  warm_step;
  logic [N_CH*OUT_W-1:0] data_vec;
  logic [N_CH-1:0]       mask_vec;

  always_comb begin
    fsm_d      = fsm_q;
    hold_cnt_d = hold_cnt_q;
    seed_ready = 1'b0;
    seed_acc   = 1'b0;
    tick       = 1'b0;
    add_seed   = 1'b0;
    warm_step  = 1'b0;
    case (fsm_q)
      RUN: begin
        seed_ready = 1'b1;
        // A seed offer wins over a due tick in the same cycle.
        if (bus.seed_valid) begin
          seed_acc   = 1'b1;
          hold_cnt_d = '0;
          fsm_d      = WARM0;
        end else if (bus.en) begin
          // >= so that lowering hold_len below the count ticks immediately.
          if (hold_cnt_q >= bus.hold_len) begin
            tick       = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      WARM0: begin
        add_seed = 1'b1;
        fsm_d    = WARM1;
      end
      WARM1: begin
        warm_step = 1'b1;
        fsm_d     = RUN;
      end
      default: fsm_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= RUN;
      hold_cnt_q  <= '0;
      seed_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      hold_cnt_q  <= hold_cnt_d;
      out_valid_q <= tick;
      if (seed_acc) seed_q <= bus.seed;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    pcg_lane #(
      .STATE_W      (STATE_W),
      .OUT_W        (OUT_W),
      .CH           (c),
      .MULT         (MULT),
      .BASE_INC     (BASE_INC),
      .OUT_MULT     (OUT_MULT),
      .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .load_zero (seed_acc),
      .add_seed  (add_seed),
      .warm_step (warm_step),
      .seed      (seed_q),
      .density   (bus.density),
      .out_data  (data_vec[c*OUT_W +: OUT_W]),
      .out_mask  (mask_vec[c])
    );
  end

  assign bus.seed_ready = seed_ready;
  assign bus.out_data   = data_vec;
  assign bus.out_mask   = mask_vec;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_pcg_noise_bank.sv
// tb/tb_pcg_noise_bank.sv - directed self-checking bench for pcg_noise_bank
module tb_pcg_noise_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcg_noise_bank_if #(.STATE_W(16), .OUT_W(8), .N_CH(4), .HOLD_W(8)) bus ();

  pcg_noise_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 16-bit state, 8-bit samples, 4 channels.
  longint     st [4];
  int         exp_data [4];
  logic [3:0] exp_mask;
  logic       exp_valid;
  logic       exp_ready;
  int         mfsm;
  int         mcnt;
  longint     mseed;

  function automatic longint r_inc(int c);
    return longint'((47989 + 2 * c) | 1);
  endfunction

  function automatic longint r_step(int c, longint s);
    return (s * 12829 + r_inc(c)) % 65536;
  endfunction

  function automatic int r_perm(longint s);
    longint sh, x, y;
    sh = s / 8192 + 3;
    x  = (s >> sh) ^ s;
    y  = (x * 62169) % 65536;
    return int'(y / 256);
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = exp_data[c][7:0];
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      st[c] = 4356 + c;
      exp_data[c] = 0;
    end
    exp_mask  = '0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    mfsm = 0;
    mcnt = 0;
    mseed = 0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic m_edge();
    exp_valid = 1'b0;
    if (rst_n === 1'b0) begin
      m_reset();
    end else begin
      case (mfsm)
        0: begin
          if (bus.seed_valid) begin
            mseed = longint'(bus.seed);
            for (int c = 0; c < 4; c++) st[c] = 0;
            mcnt = 0;
            mfsm = 1;
          end else if (bus.en) begin
            if (mcnt >= int'(bus.hold_len)) begin
              for (int c = 0; c < 4; c++) begin
                exp_data[c] = r_perm(st[c]);
                exp_mask[c] = (exp_data[c] < int'(bus.density));
                st[c] = r_step(c, st[c]);
              end
              exp_valid = 1'b1;
              mcnt = 0;
            end else begin
              mcnt++;
            end
          end
        end
        1: begin
          for (int c = 0; c < 4; c++) st[c] = (r_inc(c) + mseed + c) % 65536;
          mfsm = 2;
        end
        default: begin
          for (int c = 0; c < 4; c++) st[c] = r_step(c, st[c]);
          mfsm = 0;
        end
      endcase
    end
    exp_ready = (mfsm == 0);
  endtask

  task automatic clk_edge();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.hold_len = 8'd0;
    bus.density = 8'h80;
    bus.seed_valid = 1'b0;
    bus.seed = 16'h0;
    clk_edge();
    clk_edge();
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++; if (bus.out_mask !== 4'h0) begin errors++; $display("FAIL reset_mask got %h want 0", bus.out_mask); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.seed_ready); end
  endtask

  task automatic test_free_run();
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.hold_len = 8'd0;
    clk_edge();
    checks++; if (bus.out_data[7:0] !== 8'h41) begin errors++; $display("FAIL first_ch0 got %h want 41", bus.out_data[7:0]); end
    checks++; if (bus.out_data[15:8] !== 8'h34) begin errors++; $display("FAIL first_ch1 got %h want 34", bus.out_data[15:8]); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", bus.out_valid); end
    clk_edge();
    checks++; if (bus.out_data[7:0] !== 8'hA0) begin errors++; $display("FAIL second_ch0 got %h want a0", bus.out_data[7:0]); end
    for (int i = 0; i < 6; i++) begin
      clk_edge();
      checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL run_data[%0d] got %h want %h", i, bus.out_data, exp_vec()); end
      checks++; if (bus.out_mask !== exp_mask) begin errors++; $display("FAIL run_mask[%0d] got %h want %h", i, bus.out_mask, exp_mask); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got %b want 1", i, bus.out_valid); end
    end
  endtask

  task automatic test_hold();
    int pulses;
    logic [31:0] prev;
    pulses = 0;
    bus.hold_len = 8'd3;
    for (int i = 0; i < 16; i++) begin
      prev = bus.out_data;
      clk_edge();
      if (bus.out_valid === 1'b1) pulses++;
      checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL hold_valid[%0d] got %b want %b", i, bus.out_valid, exp_valid); end
      checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL hold_data[%0d] got %h want %h", i, bus.out_data, exp_vec()); end
      if (!exp_valid) begin
        checks++; if (bus.out_data !== prev) begin errors++; $display("FAIL hold_stable[%0d] got %h want %h", i, bus.out_data, prev); end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL hold_pulses got %0d want 4", pulses); end
  endtask

  task automatic test_en_gap();
    logic [31:0] held;
    bus.hold_len = 8'd3;
    clk_edge();
    clk_edge();
    held = bus.out_data;
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_edge();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d] got %b want 0", i, bus.out_valid); end
      checks++; if (bus.out_data !== held) begin errors++; $display("FAIL gap_data[%0d] got %h want %h", i, bus.out_data, held); end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_edge();
      checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL resume_valid[%0d] got %b want %b", i, bus.out_valid, exp_valid); end
      checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL resume_data[%0d] got %h want %h", i, bus.out_data, exp_vec()); end
    end
  endtask

  task automatic test_hold_lower();
    bus.hold_len = 8'd10;
    // Align to a fresh tick, then let the counter climb to 6.
    for (int i = 0; i < 12 && !(exp_valid === 1'b1); i++) clk_edge();
    for (int i = 0; i < 6; i++) clk_edge();
    checks++; if (mcnt != 6) begin errors++; $display("FAIL lower_setup got %0d want 6", mcnt); end
    bus.hold_len = 8'd2;
    clk_edge();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lower_tick got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL lower_data got %h want %h", bus.out_data, exp_vec()); end
  endtask

  task automatic test_seed();
    logic [31:0] held;
    bus.hold_len = 8'd0;
    bus.en = 1'b1;
    clk_edge();
    held = bus.out_data;
    bus.seed_valid = 1'b1;
    bus.seed = 16'h1234;
    checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL seed_offer_ready got %b want 1", bus.seed_ready); end
    clk_edge();
    bus.seed_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL seed_acc_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.seed_ready !== 1'b0) begin errors++; $display("FAIL warm0_ready got %b want 0", bus.seed_ready); end
    checks++; if (bus.out_data !== held) begin errors++; $display("FAIL warm0_data got %h want %h", bus.out_data, held); end
    clk_edge();
    checks++; if (bus.seed_ready !== 1'b0) begin errors++; $display("FAIL warm1_ready got %b want 0", bus.seed_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL warm1_valid got %b want 0", bus.out_valid); end
    clk_edge();
    checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL back_run_ready got %b want 1", bus.seed_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL back_run_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== held) begin errors++; $display("FAIL back_run_data got %h want %h", bus.out_data, held); end
    for (int i = 0; i < 5; i++) begin
      clk_edge();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_seed_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL post_seed_data[%0d] got %h want %h", i, bus.out_data, exp_vec()); end
    end
  endtask

  task automatic test_density();
    bus.hold_len = 8'd0;
    bus.en = 1'b1;
    bus.density = 8'h00;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      checks++; if (bus.out_mask !== 4'h0) begin errors++; $display("FAIL dens0_mask[%0d] got %h want 0", i, bus.out_mask); end
    end
    bus.density = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      clk_edge();
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus.out_mask[c] !== (exp_data[c] != 255)) begin errors++; $display("FAIL densff_mask[%0d][%0d] got %b want %b", i, c, bus.out_mask[c], exp_data[c] != 255); end
      end
    end
    bus.density = 8'h80;
    for (int i = 0; i < 6; i++) begin
      clk_edge();
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus.out_mask[c] !== ~exp_data[c][7]) begin errors++; $display("FAIL dens80_mask[%0d][%0d] got %b want %b", i, c, bus.out_mask[c], ~exp_data[c][7]); end
      end
      checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL dens80_data[%0d] got %h want %h", i, bus.out_data, exp_vec()); end
    end
  endtask

  task automatic test_reset_warm();
    bus.seed_valid = 1'b1;
    bus.seed = 16'hBEEF;
    clk_edge();
    bus.seed_valid = 1'b0;
    checks++; if (bus.seed_ready !== 1'b0) begin errors++; $display("FAIL rw_in_warm got %b want 0", bus.seed_ready); end
    rst_n = 1'b0;
    clk_edge();
    checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL rw_ready got %b want 1", bus.seed_ready); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rw_data got %h want 0", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rw_valid got %b want 0", bus.out_valid); end
    rst_n = 1'b1;
    bus.hold_len = 8'd0;
    bus.en = 1'b1;
    clk_edge();
    checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL rw_stays_run got %b want 1", bus.seed_ready); end
    checks++; if (bus.out_data[7:0] !== 8'h41) begin errors++; $display("FAIL rw_first_ch0 got %h want 41", bus.out_data[7:0]); end
    checks++; if (bus.out_data !== exp_vec()) begin errors++; $display("FAIL rw_first_data got %h want %h", bus.out_data, exp_vec()); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_free_run();
    test_hold();
    test_en_gap();
    test_hold_lower();
    test_seed();
    test_density();
    test_reset_warm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
